// File: rtl/tmr_recovery_ctrl.sv
// tmr_recovery_ctrl: stalls and reloads the TMR cores on voter disagreement, with
// resync on single faults, checkpoint rollback on no-majority and sticky fatal escalation.
module tmr_recovery_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          SYNC_CYCLES = 2,
   parameter int          MAX_RETRY   = 3,
   parameter int          CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic [2:0]       Voter_state,
   input  logic [31:0]      PC_Top,
   output logic             stall,
   output logic             pc_load_en,
   output logic [31:0]      pc_load_val,
   output logic [2:0]       fault_core,
   output logic [CNT_W-1:0] fault_cnt_A,
   output logic [CNT_W-1:0] fault_cnt_B,
   output logic [CNT_W-1:0] fault_cnt_C,
   output logic [3:0]       retry_cnt,
   output logic             fatal,
   output logic [2:0]       ctrl_state
);
   typedef enum logic [2:0] {RUN = 3'd0, SYNC = 3'd1, ROLLBACK = 3'd2, FAIL = 3'd3} state_t;
   localparam logic [3:0] SYNC_LAST = 4'(SYNC_CYCLES - 1);
   localparam logic [3:0] MAX_R     = 4'(MAX_RETRY);
   state_t      state, n_state;
   logic [3:0]  cnt, n_cnt, n_retry;
   logic [31:0] ckpt, n_ckpt, n_load_val;
   logic        n_load_en;
   logic [2:0]  blame;
   assign ctrl_state = state;
   // one-hot {A,B,C} of the core outvoted by the other two; zero unless a single fault is seen in RUN
   assign blame = (state != RUN)          ? 3'b000 :
                  (Voter_state == 3'b100) ? 3'b001 :
                  (Voter_state == 3'b001) ? 3'b010 :
                  (Voter_state == 3'b010) ? 3'b100 : 3'b000;
   always_comb begin
      n_state    = state;
      n_cnt      = cnt;
      n_load_en  = 1'b0;
      n_load_val = pc_load_val;
      n_ckpt     = ckpt;
      n_retry    = retry_cnt;
      case (state)
         RUN: begin
            if (Voter_state == 3'b111) begin
               n_ckpt  = PC_Top;
               n_retry = 4'd0;
            end else if (blame != 3'b000) begin
               n_state    = SYNC;
               n_cnt      = SYNC_LAST;
               n_load_en  = 1'b1;
               n_load_val = PC_Top;
            end else if (retry_cnt < MAX_R) begin
               n_state    = ROLLBACK;
               n_cnt      = SYNC_LAST;
               n_load_en  = 1'b1;
               n_load_val = ckpt;
               n_retry    = retry_cnt + 4'd1;
            end else begin
               n_state = FAIL;
            end
         end
         SYNC, ROLLBACK: begin
            if (cnt == 4'd0) n_state = RUN;
            else n_cnt = cnt - 4'd1;
         end
         default: n_state = FAIL;
      endcase
   end
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state       <= RUN;
         cnt         <= 4'd0;
         stall       <= 1'b0;
         pc_load_en  <= 1'b0;
         pc_load_val <= RESET_PC;
         ckpt        <= RESET_PC;
         fault_core  <= 3'b000;
         fault_cnt_A <= '0;
         fault_cnt_B <= '0;
         fault_cnt_C <= '0;
         retry_cnt   <= 4'd0;
         fatal       <= 1'b0;
      end else begin
         state       <= n_state;
         cnt         <= n_cnt;
         stall       <= n_state != RUN;
         pc_load_en  <= n_load_en;
         pc_load_val <= n_load_val;
         ckpt        <= n_ckpt;
         fault_core  <= (blame != 3'b000) ? blame : fault_core;
         fault_cnt_A <= fault_cnt_A + CNT_W'(blame[2] && !(&fault_cnt_A));
         fault_cnt_B <= fault_cnt_B + CNT_W'(blame[1] && !(&fault_cnt_B));
         fault_cnt_C <= fault_cnt_C + CNT_W'(blame[0] && !(&fault_cnt_C));
         retry_cnt   <= n_retry;
         fatal       <= n_state == FAIL;
      end
   end
endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// tb_tmr_recovery_ctrl: scenario tasks drive votes; expected reload PCs are queued
// and matched against each pc_load_en strobe by a monitor.
module tb_tmr_recovery_ctrl;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   logic        clk = 1'b0, rst_in = 1'b0, stall, pc_load_en, fatal;
   logic [2:0]  Voter_state = 3'b111, fault_core, ctrl_state;
   logic [31:0] PC_Top = 32'h0, pc_load_val;
   logic [7:0]  fault_cnt_A, fault_cnt_B, fault_cnt_C;
   logic [3:0]  retry_cnt;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc;
   int          checks = 0, passes = 0;

   tmr_recovery_ctrl #(.RESET_PC(RESET_PC), .SYNC_CYCLES(2), .MAX_RETRY(3), .CNT_W(8)) dut (
      .clk(clk), .rst_in(rst_in), .Voter_state(Voter_state), .PC_Top(PC_Top),
      .stall(stall), .pc_load_en(pc_load_en), .pc_load_val(pc_load_val),
      .fault_core(fault_core), .fault_cnt_A(fault_cnt_A), .fault_cnt_B(fault_cnt_B),
      .fault_cnt_C(fault_cnt_C), .retry_cnt(retry_cnt), .fatal(fatal), .ctrl_state(ctrl_state));

   always #5 clk = ~clk;

   // every reload strobe must match the oldest queued expectation
   always @(posedge clk) begin
      #1;
      if (rst_in && pc_load_en) begin
         checks++;
         if (exp_q.size() == 0) $display("FAIL strobe_unexpected: pc_load_val=%h, no reload expected", pc_load_val);
         else begin
            exp_pc = exp_q.pop_front();
            if (pc_load_val !== exp_pc) $display("FAIL strobe_pc: pc_load_val=%h expected %h", pc_load_val, exp_pc);
            else passes++;
         end
      end
   end

   task automatic tick(input logic [2:0] v, input logic [31:0] pc);
      Voter_state = v;
      PC_Top = pc;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_in = 1'b0;
      Voter_state = 3'b111;
      PC_Top = 32'h0;
      #12;
      @(negedge clk);
      rst_in = 1'b1;
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst_in = 1'b0;
      #12;
      checks++;
      if ({stall, pc_load_en, fatal, ctrl_state, retry_cnt, fault_core} !== 13'd0)
         $display("FAIL reset_ctrl: stall=%b en=%b fatal=%b state=%0d retry=%0d core=%b expected all 0",
                  stall, pc_load_en, fatal, ctrl_state, retry_cnt, fault_core);
      else passes++;
      checks++;
      if ({fault_cnt_A, fault_cnt_B, fault_cnt_C} !== 24'd0 || pc_load_val !== RESET_PC)
         $display("FAIL reset_vals: cnts=%h/%h/%h pc=%h expected 0 and %h", fault_cnt_A, fault_cnt_B, fault_cnt_C, pc_load_val, RESET_PC);
      else passes++;
      @(negedge clk);
      rst_in = 1'b1;
      @(posedge clk);
      #2;
   endtask

   task automatic test_clean();
      for (int i = 0; i < 5; i++) begin
         tick(3'b111, 32'(i * 4));
         checks++;
         if (stall !== 1'b0 || ctrl_state !== 3'd0) $display("FAIL clean_run: stall=%b state=%0d expected 0/0", stall, ctrl_state);
         else passes++;
      end
      exp_q.push_back(32'h10);
      tick(3'b000, 32'h14);
      checks++;
      if (ctrl_state !== 3'd2 || retry_cnt !== 4'd1) $display("FAIL clean_ckpt: state=%0d retry=%0d expected 2/1", ctrl_state, retry_cnt);
      else passes++;
      tick(3'b111, 32'h0);
      tick(3'b111, 32'h0);
      tick(3'b111, 32'h18);
   endtask

   task automatic test_single_fault();
      tick(3'b111, 32'h20);
      exp_q.push_back(32'h24);
      tick(3'b100, 32'h24);
      checks++;
      if (ctrl_state !== 3'd1 || stall !== 1'b1 || pc_load_en !== 1'b1)
         $display("FAIL sync_entry: state=%0d stall=%b en=%b expected 1/1/1", ctrl_state, stall, pc_load_en);
      else passes++;
      checks++;
      if (fault_core !== 3'b001 || fault_cnt_C !== 8'd1 || fault_cnt_A !== 8'd0)
         $display("FAIL sync_blame: core=%b cntC=%0d cntA=%0d expected 001/1/0", fault_core, fault_cnt_C, fault_cnt_A);
      else passes++;
      tick(3'b000, 32'h99);
      checks++;
      if (stall !== 1'b1 || pc_load_en !== 1'b0 || ctrl_state !== 3'd1)
         $display("FAIL sync_hold: stall=%b en=%b state=%0d expected 1/0/1", stall, pc_load_en, ctrl_state);
      else passes++;
      tick(3'b000, 32'h99);
      checks++;
      if (stall !== 1'b0 || ctrl_state !== 3'd0 || retry_cnt !== 4'd0)
         $display("FAIL sync_exit: stall=%b state=%0d retry=%0d expected 0/0/0", stall, ctrl_state, retry_cnt);
      else passes++;
   endtask

   task automatic test_rollback();
      tick(3'b111, 32'h40);
      exp_q.push_back(32'h40);
      tick(3'b000, 32'h44);
      checks++;
      if (ctrl_state !== 3'd2 || retry_cnt !== 4'd1 || stall !== 1'b1)
         $display("FAIL rollback_entry: state=%0d retry=%0d stall=%b expected 2/1/1", ctrl_state, retry_cnt, stall);
      else passes++;
      tick(3'b111, 32'h0);
      tick(3'b111, 32'h0);
      checks++;
      if (stall !== 1'b0 || retry_cnt !== 4'd1) $display("FAIL rollback_exit: stall=%b retry=%0d expected 0/1", stall, retry_cnt);
      else passes++;
      tick(3'b111, 32'h48);
      checks++;
      if (retry_cnt !== 4'd0) $display("FAIL rollback_clear: retry=%0d expected 0", retry_cnt);
      else passes++;
   endtask

   task automatic test_fatal();
      tick(3'b111, 32'h80);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(32'h80);
         tick(3'b000, 32'h100 + 32'(i));
         checks++;
         if (ctrl_state !== 3'd2 || retry_cnt !== 4'(i + 1))
            $display("FAIL fatal_retry%0d: state=%0d retry=%0d expected 2/%0d", i, ctrl_state, retry_cnt, i + 1);
         else passes++;
         tick(3'b111, 32'h200);
         tick(3'b111, 32'h204);
      end
      tick(3'b000, 32'h300);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (ctrl_state !== 3'd3 || fatal !== 1'b1 || stall !== 1'b1 || pc_load_en !== 1'b0)
            $display("FAIL fatal_hold%0d: state=%0d fatal=%b stall=%b en=%b expected 3/1/1/0", i, ctrl_state, fatal, stall, pc_load_en);
         else passes++;
         tick(3'b111, 32'h400);
      end
      rst_in = 1'b0;
      #1;
      checks++;
      if (fatal !== 1'b0 || ctrl_state !== 3'd0 || stall !== 1'b0)
         $display("FAIL fatal_reset: fatal=%b state=%0d stall=%b expected 0/0/0", fatal, ctrl_state, stall);
      else passes++;
      do_reset();
   endtask

   task automatic test_back_to_back();
      exp_q.push_back(32'h200);
      tick(3'b001, 32'h200);
      tick(3'b111, 32'h0);
      tick(3'b111, 32'h0);
      exp_q.push_back(32'h300);
      tick(3'b001, 32'h300);
      checks++;
      if (pc_load_en !== 1'b1 || fault_core !== 3'b010 || fault_cnt_B !== 8'd2)
         $display("FAIL b2b: en=%b core=%b cntB=%0d expected 1/010/2", pc_load_en, fault_core, fault_cnt_B);
      else passes++;
      tick(3'b111, 32'h0);
      tick(3'b111, 32'h0);
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         exp_q.push_back(32'h1000 + 32'(i * 4));
         tick(3'b010, 32'h1000 + 32'(i * 4));
         tick(3'b111, 32'h0);
         tick(3'b111, 32'h0);
      end
      checks++;
      if (fault_cnt_A !== 8'd255 || fault_cnt_B !== 8'd0 || fault_cnt_C !== 8'd0 || fault_core !== 3'b100)
         $display("FAIL saturate: cnt=%0d/%0d/%0d core=%b expected 255/0/0/100", fault_cnt_A, fault_cnt_B, fault_cnt_C, fault_core);
      else passes++;
   endtask

   task automatic test_async_reset();
      do_reset();
      exp_q.push_back(32'h500);
      tick(3'b100, 32'h500);
      #1;
      rst_in = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || pc_load_en !== 1'b0 || fatal !== 1'b0 || ctrl_state !== 3'd0)
         $display("FAIL async_reset: stall=%b en=%b fatal=%b state=%0d expected 0/0/0/0", stall, pc_load_en, fatal, ctrl_state);
      else passes++;
      @(negedge clk);
      rst_in = 1'b1;
      exp_q.push_back(RESET_PC);
      tick(3'b110, 32'h600);
      checks++;
      if (ctrl_state !== 3'd2 || retry_cnt !== 4'd1) $display("FAIL inconsistent_vote: state=%0d retry=%0d expected 2/1", ctrl_state, retry_cnt);
      else passes++;
      tick(3'b111, 32'h0);
      tick(3'b111, 32'h0);
   endtask

   initial begin
      test_reset();
      test_clean();
      test_single_fault();
      test_rollback();
      test_fatal();
      test_back_to_back();
      test_saturation();
      test_async_reset();
      checks++;
      if (exp_q.size() != 0) $display("FAIL strobe_missing: %0d expected reloads never seen", exp_q.size());
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/tmr_recovery_ctrl.md
# tmr_recovery_ctrl

Recovery sequencer for the triple-modular-redundant RISC-V core. It watches the per-cycle comparison vector and voted PC from the voter and checkpoints the last fully agreed PC. On a disagreement it stalls all three cores and reloads a common PC. A single-core fault resynchronises the cores at the voted PC; a no-majority event rolls them back to the checkpoint, and repeated unrecoverable events escalate to a sticky fatal state.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: checkpoint and load value after reset.
- SYNC_CYCLES, 2: stall length in SYNC and ROLLBACK states (1..15).
- MAX_RETRY, 3: consecutive rollbacks allowed before FAIL (1..15).
- CNT_W, 8: width of per-core fault counters.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- Voter_state  in  3  comparison vector {A==B, B==C, A==C} from voter.
- PC_Top  in  32  voted PC from voter.
- stall  out  1  hold all three cores (no PC update, no writeback, no MemWrite).
- pc_load_en  out  1  one-cycle strobe: all cores load pc_load_val.
- pc_load_val  out  32  PC to load, valid while pc_load_en=1.
- fault_core  out  3  one-hot {A,B,C} of the core blamed in the last single fault; 0 if none yet.
- fault_cnt_A/B/C  out  CNT_W  saturating count of single faults blamed on each core.
- retry_cnt  out  4  consecutive rollbacks since the last clean vote.
- fatal  out  1  sticky unrecoverable error flag.
- ctrl_state  out  3  FSM state: RUN=0, SYNC=1, ROLLBACK=2, FAIL=3.

## Operation
Vote classification is sampled only in RUN:
- 111: clean.
- 100: C faulty. 001: B faulty. 010: A faulty. Each of these is a single fault.
- 000, 110, 101, 011: no majority. The last three are inconsistent and are handled like 000.

RUN:
- Clean: checkpoint <= PC_Top and retry_cnt <= 0.
- Single fault: go to SYNC. Load value = PC_Top sampled this cycle. Set fault_core. Increment that core's counter, saturating at 2^CNT_W-1.
- No majority with retry_cnt < MAX_RETRY: go to ROLLBACK with load value = checkpoint. retry_cnt increments.
- No majority with retry_cnt == MAX_RETRY: go to FAIL.

SYNC and ROLLBACK:
- stall=1 for SYNC_CYCLES cycles. pc_load_en=1 on the first of these cycles only.
- Voter_state is ignored. Checkpoint is unchanged.
- After the last cycle, return to RUN.

FAIL:
- stall=1, fatal=1, pc_load_en=0. Only reset exits this state.

Other rules:
- All outputs are registered (Moore).
- pc_load_val holds its last value outside the strobe.
- Counters do not wrap. retry_cnt is bounded by MAX_RETRY.

## Timing
Reset (rst_in=0, asynchronous) sets:
- state=RUN, stall=0, pc_load_en=0, pc_load_val=RESET_PC, checkpoint=RESET_PC.
- fault_core=0, all counters=0, retry_cnt=0, fatal=0.

Release from reset is synchronous to the next clk edge. Reset asserted mid-SYNC, mid-ROLLBACK or in FAIL aborts immediately to the reset values.

Event latency:
- A fault vote at edge t gives stall=1 and pc_load_en=1 after edge t, with ctrl_state=SYNC or ROLLBACK.
- stall deasserts after edge t+SYNC_CYCLES.
- The first vote sampled again is at edge t+SYNC_CYCLES+1.

Cycle accounting:
- A clean vote and a checkpoint update happen in the same cycle. A fault vote never updates the checkpoint.
- After a rollback, retry_cnt stays nonzero until a clean vote is seen in RUN.
- Back-to-back single faults each cost exactly 1+SYNC_CYCLES cycles before the next sample.

## Test plan
- Reset, then 5 clean votes with PC_Top=0x0,0x4,0x8,0xC,0x10 -> stall stays 0, checkpoint=0x10, all counters 0, ctrl_state=0.
- Clean vote at PC 0x20, then Voter_state=100 with PC_Top=0x24 -> next cycle pc_load_en=1, pc_load_val=0x24, fault_core=001, fault_cnt_C=1, stall high 2 cycles, then RUN.
- Clean vote at PC 0x40, then 000 -> pc_load_val=0x40, retry_cnt=1. Clean vote afterwards -> retry_cnt=0.
- MAX_RETRY=3: four no-majority events with no clean vote between them -> three rollbacks to the same checkpoint, then ctrl_state=3, fatal=1, stall=1 held until rst_in is pulsed.
- 300 single faults blamed on A (Voter_state=010), CNT_W=8 -> fault_cnt_A=255 and holds; fault_cnt_B and fault_cnt_C stay 0.
- Assert rst_in=0 in the middle of a SYNC stall (no clock edge) -> stall=0, pc_load_en=0, fatal=0 and ctrl_state=0 immediately. An inconsistent vote 110 after release -> treated as a rollback.
